y_stream_framer: RTL and testbench

Converts an upstream valid/ready luma byte stream (with start-of-frame marker) into the coordinate-tagged pixel stream consumed by the Y-channel histogram equalizer. It emits `pixel_valid`/`x`/`y`/`y_data` with fixed line and frame blanking. Vertical blanking is sized to cover the equalizer's between-frame LUT rebuild, which takes about 770 cycles. It sits between the capture/colour-conversion front end and the equalizer.

---
 rtl/video_pkg.sv | 28 ++
 rtl/y_stream_framer_if.sv | 10 +
 rtl/frame_pos_counter.sv | 48 ++++
 rtl/y_stream_framer.sv | 152 +++++++++++++++
 tb/tb_y_stream_framer.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_pkg.sv
// Shared video definitions for the luma stream framer: state encoding,
// default raster geometry and counter widths.
package video_pkg;

  localparam int COORD_W = 10;
  localparam int BLANK_W = 16;

  localparam int DEF_H_ACTIVE       = 640;
  localparam int DEF_V_ACTIVE       = 480;
  localparam int DEF_H_BLANK        = 160;
  localparam int DEF_V_BLANK_CYCLES = 1600;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [BLANK_W-1:0] blank_t;

  typedef enum logic [1:0] {
    S_WAIT_SOF = 2'd0,
    S_ACTIVE   = 2'd1,
    S_HBLANK   = 2'd2,
    S_VBLANK   = 2'd3
  } framer_state_e;

  // Blank counters count down from cycles-1 to 0, so a phase lasts 'cycles'.
  function automatic blank_t blank_load(input int cycles);
    return BLANK_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/y_stream_framer_if.sv
// Upstream luma byte stream: valid/ready handshake plus start-of-frame flag.
interface y_stream_framer_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_sof;
  logic       s_ready;

  modport master (output s_valid, s_data, s_sof, input s_ready);
  modport slave  (input s_valid, s_data, s_sof, output s_ready);
endinterface

// File: rtl/frame_pos_counter.sv
// Raster position counter. 'origin' makes the current position read as (0,0)
// (first pixel of a frame), 'step' advances past the current position,
// wrapping at end of line and end of frame.
module frame_pos_counter
  import video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   origin,
  input  logic   step,
  output coord_t x,
  output coord_t y,
  output logic   eol,
  output logic   eof
);

  localparam coord_t X_LAST = COORD_W'(H_ACTIVE - 1);
  localparam coord_t Y_LAST = COORD_W'(V_ACTIVE - 1);

  coord_t x_q, y_q;

  assign x   = origin ? '0 : x_q;
  assign y   = origin ? '0 : y_q;
  assign eol = (x == X_LAST);
  assign eof = eol && (y == Y_LAST);

  // Advance the raster position after each emitted pixel.
  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (step) begin
      if (eol) begin
        x_q <= '0;
        y_q <= eof ? '0 : y + coord_t'(1);
      end else begin
        x_q <= x + coord_t'(1);
        y_q <= y;
      end
    end
  end

endmodule

// File: rtl/y_stream_framer.sv
// Luma stream framer: turns a valid/ready byte stream with start-of-frame
// into a coordinate-tagged pixel stream with fixed line and frame blanking.
// Build option FRAMER_SOF_RESYNC_EN: a start-of-frame seen mid-frame aborts
// the frame and restarts at (0,0); otherwise it is plain data.
module y_stream_framer
  import video_pkg::*;
#(
  parameter int         H_ACTIVE       = DEF_H_ACTIVE,
  parameter int         V_ACTIVE       = DEF_V_ACTIVE,
  parameter int         H_BLANK        = DEF_H_BLANK,
  parameter int         V_BLANK_CYCLES = DEF_V_BLANK_CYCLES,
  parameter logic [7:0] PAD_VALUE      = 8'd0
) (
  input  logic                 clk,
  input  logic                 rst,
  y_stream_framer_if.slave     sif,
  output logic                 pixel_valid,
  output coord_t               x_out,
  output coord_t               y_out,
  output logic [7:0]           y_data_out,
  output logic                 frame_end,
  output logic                 underflow,
  output logic                 sof_err
);

  localparam blank_t H_LOAD = blank_load(H_BLANK);
  localparam blank_t V_LOAD = blank_load(V_BLANK_CYCLES);

  framer_state_e state_q, state_d;
  blank_t        blank_q, blank_d;

  logic       pv_d, fe_d, uf_d, se_d;
  coord_t     x_d, y_d;
  logic [7:0] data_d, pix_data;
  logic       emit, beat_sof;

  logic   pos_origin, pos_step, pos_eol, pos_eof;
  coord_t pos_x, pos_y;

  frame_pos_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_pos (
    .clk    (clk),
    .rst    (rst),
    .origin (pos_origin),
    .step   (pos_step),
    .x      (pos_x),
    .y      (pos_y),
    .eol    (pos_eol),
    .eof    (pos_eof)
  );

  assign beat_sof    = sif.s_valid && sif.s_sof;
  assign sif.s_ready = (state_q == S_WAIT_SOF) || (state_q == S_ACTIVE);

  // Next state, blanking count and next registered outputs.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    blank_d    = blank_q;
    pv_d       = 1'b0;
    x_d        = x_out;
    y_d        = y_out;
    data_d     = y_data_out;
    fe_d       = 1'b0;
    uf_d       = underflow;
    se_d       = 1'b0;
    emit       = 1'b0;
    pix_data   = PAD_VALUE;
    pos_origin = 1'b0;
    pos_step   = 1'b0;

    unique case (state_q)
      S_WAIT_SOF: begin
        // Non-SOF beats are accepted and dropped.
        if (beat_sof) begin
          emit       = 1'b1;
          pos_origin = 1'b1;
          pix_data   = sif.s_data;
        end
      end
      S_ACTIVE: begin
        emit = 1'b1;
        se_d = beat_sof;
`ifdef FRAMER_SOF_RESYNC_EN
        pos_origin = beat_sof;
`endif
        if (sif.s_valid) begin
          pix_data = sif.s_data;
        end else begin
          pix_data = PAD_VALUE;
          uf_d     = 1'b1;
        end
      end
      S_HBLANK: begin
        if (blank_q == '0) state_d = S_ACTIVE;
        else               blank_d = blank_q - blank_t'(1);
      end
      S_VBLANK: begin
        if (blank_q == '0) state_d = S_WAIT_SOF;
        else               blank_d = blank_q - blank_t'(1);
      end
      default: state_d = S_WAIT_SOF;
    endcase

    if (emit) begin
      pv_d     = 1'b1;
      x_d      = pos_x;
      y_d      = pos_y;
      data_d   = pix_data;
      pos_step = 1'b1;
      if (pos_eof) begin
        fe_d    = 1'b1;
        state_d = S_VBLANK;
        blank_d = V_LOAD;
      end else if (pos_eol) begin
        state_d = S_HBLANK;
        blank_d = H_LOAD;
      end else begin
        state_d = S_ACTIVE;
      end
    end
  end

  // State, blanking counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_WAIT_SOF;
      blank_q     <= '0;
      pixel_valid <= 1'b0;
      x_out       <= '0;
      y_out       <= '0;
      y_data_out  <= '0;
      frame_end   <= 1'b0;
      underflow   <= 1'b0;
      sof_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      blank_q     <= blank_d;
      pixel_valid <= pv_d;
      x_out       <= x_d;
      y_out       <= y_d;
      y_data_out  <= data_d;
      frame_end   <= fe_d;
      underflow   <= uf_d;
      sof_err     <= se_d;
    end
  end

endmodule

// File: tb/tb_y_stream_framer.sv
// Bench for y_stream_framer on a small 8x4 raster. A schedule-based model
// predicts every output from the time the frame's SOF beat was accepted;
// directed runs add hand-computed expectations on top.
module tb_y_stream_framer;
  import video_pkg::*;

  localparam int H   = 8;
  localparam int V   = 4;
  localparam int HB  = 2;
  localparam int VB  = 800;
  localparam int L   = H + HB;
  localparam int P   = H * V + (V - 1) * HB + VB;
  localparam logic [7:0] PAD = 8'h00;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  y_stream_framer_if sif ();

  logic       pixel_valid, frame_end, underflow, sof_err;
  coord_t     x_out, y_out;
  logic [7:0] y_data_out;

  y_stream_framer #(
    .H_ACTIVE       (H),
    .V_ACTIVE       (V),
    .H_BLANK        (HB),
    .V_BLANK_CYCLES (VB),
    .PAD_VALUE      (PAD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sif         (sif),
    .pixel_valid (pixel_valid),
    .x_out       (x_out),
    .y_out       (y_out),
    .y_data_out  (y_data_out),
    .frame_end   (frame_end),
    .underflow   (underflow),
    .sof_err     (sof_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: frame schedule from the SOF edge ----------------
  int         ecount   = 0;
  bit         in_frame = 1'b0;
  int         e0       = 0;
  bit         exp_pv = 1'b0, exp_fe = 1'b0, exp_uf = 1'b0, exp_se = 1'b0;
  bit         exp_rdy = 1'b1;
  int         exp_x = 0, exp_y = 0;
  logic [7:0] exp_d = 8'h00;
  bit         chk_en = 1'b0;

  always @(posedge clk) begin : model
    int d, line, col, e, f0;
    bit inf, vld, sof, o_pv, o_fe, o_uf, o_se, o_rdy;
    int o_x, o_y;
    logic [7:0] dat, o_d;
    e = ecount + 1; inf = in_frame; f0 = e0;
    vld = sif.s_valid; sof = sif.s_sof; dat = sif.s_data;
    o_pv = 1'b0; o_fe = 1'b0; o_se = 1'b0; o_uf = exp_uf;
    o_x = exp_x; o_y = exp_y; o_d = exp_d;
    if (rst) begin
      inf = 1'b0; o_uf = 1'b0; o_x = 0; o_y = 0; o_d = 8'h00;
    end else if (!inf) begin
      if (vld && sof) begin
        inf = 1'b1; f0 = e;
        o_pv = 1'b1; o_x = 0; o_y = 0; o_d = dat;
      end
    end else begin
      d = e - f0; line = d / L; col = d % L;
      if (line < V && col < H) begin
        o_pv = 1'b1; o_x = col; o_y = line;
        if (vld && sof) begin
          o_se = 1'b1; o_d = dat;
`ifdef FRAMER_SOF_RESYNC_EN
          f0 = e; o_x = 0; o_y = 0;
`else
          o_fe = (col == H - 1) && (line == V - 1);
`endif
        end else begin
          o_d  = vld ? dat : PAD;
          o_uf = o_uf | !vld;
          o_fe = (col == H - 1) && (line == V - 1);
        end
      end
    end
    o_rdy = 1'b1;
    if (inf) begin
      d = e + 1 - f0;
      if (d >= P) inf = 1'b0;
      else        o_rdy = ((d / L) < V) && ((d % L) < H);
    end
    ecount <= e; in_frame <= inf; e0 <= f0;
    exp_pv <= o_pv; exp_fe <= o_fe; exp_uf <= o_uf; exp_se <= o_se;
    exp_x <= o_x; exp_y <= o_y; exp_d <= o_d; exp_rdy <= o_rdy;
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("s_ready", sif.s_ready, exp_rdy);
      check("pixel_valid", pixel_valid, exp_pv);
      check("frame_end", frame_end, exp_fe);
      check("underflow", underflow, exp_uf);
      check("sof_err", sof_err, exp_se);
      if (exp_pv) begin
        check("x_out", x_out, exp_x);
        check("y_out", y_out, exp_y);
        check("y_data_out", y_data_out, exp_d);
      end
    end
  end

  // ---------------- directed source with per-run statistics ----------------
  int pv_cnt, fe_cnt, se_cnt, fe_x, fe_y;
  int hb_runs, hb_min, hb_max, vb_run;
  bit first_seen;
  int first_x, first_y, first_d, probe_data;

  task automatic run_src(input int n_cyc, input int n_drop, input int d_pre,
                         input int d_sof, input int gap_pix, input int sof_pix,
                         input int rst_pix, input int probe_x, input int probe_y);
    int pix, drops, dval, run;
    bit sent, sof_done, rdy;
    pv_cnt = 0; fe_cnt = 0; se_cnt = 0; fe_x = -1; fe_y = -1;
    hb_runs = 0; hb_min = 9999; hb_max = 0; vb_run = 0;
    first_seen = 1'b0; first_x = -1; first_y = -1; first_d = -1; probe_data = -1;
    pix = 0; drops = 0; dval = d_sof; run = 0; sent = 1'b0; sof_done = 1'b0;
    for (int i = 0; i < n_cyc; i++) begin
      @(negedge clk);
      if (pixel_valid) begin
        pv_cnt++;
        if (!first_seen) begin
          first_seen = 1'b1; first_x = x_out; first_y = y_out; first_d = y_data_out;
        end
        if (x_out == probe_x && y_out == probe_y) probe_data = y_data_out;
      end
      if (frame_end) begin fe_cnt++; fe_x = x_out; fe_y = y_out; end
      if (sof_err) se_cnt++;
      rdy = sif.s_ready;
      if (sent) begin
        if (!rdy) run++;
        else if (run > 0) begin
          if (run < 100) begin
            hb_runs++;
            if (run < hb_min) hb_min = run;
            if (run > hb_max) hb_max = run;
          end else vb_run = run;
          run = 0;
        end
      end
      if (sent && rdy && pix == rst_pix) begin
        rst = 1'b1; sif.s_valid = 1'b0; sif.s_sof = 1'b0;
        @(negedge clk);
        check("rst_pixel_valid", pixel_valid, 0);
        check("rst_x_out", x_out, 0);
        check("rst_y_out", y_out, 0);
        check("rst_y_data_out", y_data_out, 0);
        check("rst_frame_end", frame_end, 0);
        check("rst_underflow", underflow, 0);
        check("rst_sof_err", sof_err, 0);
        check("rst_s_ready", sif.s_ready, 1);
        rst = 1'b0;
        return;
      end
      if (!sent) begin
        sif.s_valid = 1'b1;
        if (drops < n_drop) begin sif.s_sof = 1'b0; sif.s_data = 8'(d_pre + drops); end
        else begin sif.s_sof = 1'b1; sif.s_data = 8'(dval); end
      end else if (pix < H * V) begin
        sif.s_sof   = (pix == sof_pix) && !sof_done;
        sif.s_valid = !(pix == gap_pix && rdy);
        sif.s_data  = 8'(dval);
      end else begin
        sif.s_valid = 1'b0; sif.s_sof = 1'b0;
      end
      if (rdy) begin
        if (!sent) begin
          if (sif.s_sof) begin sent = 1'b1; pix = 1; dval++; end
          else drops++;
        end else if (pix < H * V) begin
          if (sif.s_valid) begin
            dval++;
            if (sif.s_sof) begin
              sof_done = 1'b1;
`ifdef FRAMER_SOF_RESYNC_EN
              pix = 1;
`else
              pix++;
`endif
            end else pix++;
          end else pix++;
        end
      end
    end
    sif.s_valid = 1'b0; sif.s_sof = 1'b0;
  endtask

  initial begin
    sif.s_valid = 1'b0; sif.s_sof = 1'b0; sif.s_data = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_pixel_valid", pixel_valid, 0);
    check("reset_x_out", x_out, 0);
    check("reset_y_out", y_out, 0);
    check("reset_y_data_out", y_data_out, 0);
    check("reset_frame_end", frame_end, 0);
    check("reset_underflow", underflow, 0);
    check("reset_sof_err", sof_err, 0);
    check("reset_s_ready", sif.s_ready, 1);
    rst = 1'b0;
    chk_en = 1'b1;

    // Continuous stream, SOF on the first beat.
    run_src(900, 0, 0, 'h10, -1, -1, -1, 0, 1);
    check("t1_pixels", pv_cnt, 32);
    check("t1_frame_end_count", fe_cnt, 1);
    check("t1_frame_end_x", fe_x, 7);
    check("t1_frame_end_y", fe_y, 3);
    check("t1_first_data", first_d, 'h10);
    check("t1_pixel_0_1_data", probe_data, 'h18);
    check("t1_hblank_runs", hb_runs, 3);
    check("t1_hblank_min", hb_min, 2);
    check("t1_hblank_max", hb_max, 2);
    check("t1_vblank_len", vb_run, 800);

    // Three non-SOF beats dropped, then SOF carrying 0x5A.
    run_src(900, 3, 'h11, 'h5A, -1, -1, -1, -1, -1);
    check("t2_first_x", first_x, 0);
    check("t2_first_y", first_y, 0);
    check("t2_first_data", first_d, 'h5A);
    check("t2_pixels", pv_cnt, 32);

    // Upstream stall at (3,1).
    run_src(900, 0, 0, 'h20, 11, -1, -1, 3, 1);
    check("t3_pad_data", probe_data, 0);
    check("t3_pixels", pv_cnt, 32);
    check("t3_frame_end_x", fe_x, 7);
    check("t3_frame_end_y", fe_y, 3);
    check("t3_underflow_sticky", underflow, 1);

    // Misplaced SOF at (5,2).
`ifdef FRAMER_SOF_RESYNC_EN
    run_src(900, 0, 0, 'h40, -1, 21, -1, 0, 0);
    check("t4_restart_data", probe_data, 'h55);
    check("t4_pixels", pv_cnt, 53);
`else
    run_src(900, 0, 0, 'h40, -1, 21, -1, 5, 2);
    check("t4_data_at_5_2", probe_data, 'h55);
    check("t4_pixels", pv_cnt, 32);
`endif
    check("t4_sof_err_count", se_cnt, 1);
    check("t4_frame_end_count", fe_cnt, 1);
    check("t4_underflow_sticky", underflow, 1);

    // Reset at (4,2), then a fresh frame.
    run_src(100, 0, 0, 'h60, -1, -1, 20, -1, -1);
    check("t5_pixels_before_reset", pv_cnt, 20);
    check("t5_frame_end_before_reset", fe_cnt, 0);
    run_src(900, 0, 0, 'h70, -1, -1, -1, -1, -1);
    check("t5_first_x", first_x, 0);
    check("t5_first_y", first_y, 0);
    check("t5_first_data", first_d, 'h70);
    check("t5_pixels", pv_cnt, 32);
    check("t5_underflow_clear", underflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
